// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the two-master bus arbiter.
//   arb_state_e   - arbiter FSM states (IDLE, GRANT_M0, GRANT_M1)
//   master_idx_e  - identifies a master (M0 = instruction fetch, M1 = data)
//   to_cnt_width  - watchdog counter width, $clog2(TIMEOUT_CYCLES+1)
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_idx_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // Width needed to hold the value TIMEOUT_CYCLES itself.
  function automatic int unsigned to_cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/bus_arb_watchdog.sv
// bus_arb_watchdog: stall counter that aborts a granted transfer whose slave
// never acknowledges. Only present when BUS_ARB_TIMEOUT_EN is defined.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   active_i      - a master currently holds the grant
//   stall_i       - strobe is out on the bus and the slave has not acked
//   ack_i         - slave acknowledge (restarts the count)
//   timeout_o     - count reached TIMEOUT_CYCLES; abort this cycle
`ifdef BUS_ARB_TIMEOUT_EN
module bus_arb_watchdog
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic stall_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int unsigned CntW = to_cnt_width(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_o = active_i && (cnt_q == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || ack_i || timeout_o) begin
      cnt_d = '0;
    end else if (stall_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter giving two Wishbone-style masters
// (m0 = instruction fetch, m1 = data) access to one shared slave.
//   clk, rst_n            - clock, asynchronous active-low reset
//   mx_cyc_i/stb_i/we_i   - master x bus cycle, strobe, write enable
//   mx_addr_i/data_i      - master x address and write data
//   mx_data_o/ack_o/err_o - read data, acknowledge, timeout abort to master x
//   s_*_o / s_data_i/ack_i - shared slave port (slave acks combinationally)
// Optional feature: define BUS_ARB_TIMEOUT_EN to abort a grant after
// TIMEOUT_CYCLES stalled cycles; otherwise mx_err_o is constant 0.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
);

  arb_state_e  state_q, state_d;
  master_idx_e last_grant_q, last_grant_d;
  logic        req0, req1;
  logic        timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef BUS_ARB_TIMEOUT_EN
  bus_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .active_i (state_q != IDLE),
    .stall_i  (s_stb_o & ~s_ack_i),
    .ack_i    (s_ack_i),
    .timeout_o(timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  // Next-state: grants always pass through IDLE, so a tie is only ever
  // resolved here, in favour of the master not served last.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = (last_grant_q == M1) ? GRANT_M0 : GRANT_M1;
        end else if (req0) begin
          state_d = GRANT_M0;
        end else if (req1) begin
          state_d = GRANT_M1;
        end
      end
      GRANT_M0: begin
        if (!m0_cyc_i || timeout) begin
          state_d      = IDLE;
          last_grant_d = M0;
        end
      end
      GRANT_M1: begin
        if (!m1_cyc_i || timeout) begin
          state_d      = IDLE;
          last_grant_d = M1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Bus routing is combinational on the registered grant so the slave's
  // same-cycle ack reaches the master without an extra cycle. On a timeout
  // cycle the bus cycle is withdrawn and the master sees err instead of ack.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    unique case (state_q)
      GRANT_M0: begin
        s_cyc_o   = m0_cyc_i & ~timeout;
        s_stb_o   = m0_stb_i & ~timeout;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i & ~timeout;
        m0_err_o  = timeout;
      end
      GRANT_M1: begin
        s_cyc_o   = m1_cyc_i & ~timeout;
        s_stb_o   = m1_stb_i & ~timeout;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i & ~timeout;
        m1_err_o  = timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int unsigned TO = 4;
  localparam logic [31:0] GARB = 32'hA5A5_5A5A;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic [1:0]  ack, err;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        ack_en;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc_no;
  logic [31:0] q0[$], q1[$];
  int log_m[$], log_c[$];
  bit ok_main;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_addr_i(addr[0]), .m0_data_i(wd[0]),
    .m0_data_o(rdata[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_addr_i(addr[1]), .m1_data_i(wd[1]),
    .m1_data_o(rdata[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory slave: combinational ack, garbage on the data lines
  // whenever it is not serving a read.
  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;
  assign s_ack_i  = ack_en & s_cyc_o & s_stb_o;
  assign s_data_i = (s_cyc_o && s_stb_o && !s_we_o) ? mem[s_addr_o[9:2]] : GARB;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem[8'h40] <= BEEF;
      mem_ready  <= 1'b1;
    end else if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
      mem[s_addr_o[9:2]] <= s_data_o;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_no <= 0;
    else        cyc_no <= cyc_no + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every ack pops that master's expected read data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack[0]) begin
        log_m.push_back(0); log_c.push_back(int'(cyc_no) + 1);
        if (q0.size() == 0) chk("m0_unexpected_ack", 32'd1, 32'd0);
        else                chk("m0_rdata", rdata[0], q0.pop_front());
      end
      if (ack[1]) begin
        log_m.push_back(1); log_c.push_back(int'(cyc_no) + 1);
        if (q1.size() == 0) chk("m1_unexpected_ack", 32'd1, 32'd0);
        else                chk("m1_rdata", rdata[1], q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack[m]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk($sformatf("m%0d_ack_within_bound", m), 32'(ok), 32'd1);
  endtask

  task automatic single(input int m, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
    bit ok;
    if (m == 0) q0.push_back(exp); else q1.push_back(exp);
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; addr[m] = a; wd[m] = d;
    wait_ack(m, ok);
    if (ok) begin
      chk("bus_addr", s_addr_o, a);
      chk("bus_we", 32'(s_we_o), 32'(w));
      if (w) chk("bus_wdata", s_data_o, d);
      chk("other_ack", 32'(ack[1-m]), 32'd0);
      chk("other_data", rdata[1-m], 32'd0);
    end
    tick();
    cyc[m] = 1'b0; stb[m] = 1'b0;
    tick();
  endtask

  task automatic expect_log(input string tag, input int idx, input int m, input int c);
    if (idx >= log_m.size()) begin
      chk($sformatf("%s_missing_grant[%0d]", tag, idx), 32'd0, 32'd1);
      return;
    end
    chk($sformatf("%s_master[%0d]", tag, idx), 32'(log_m[idx]), 32'(m));
    if (c >= 0) chk($sformatf("%s_cycle[%0d]", tag, idx), 32'(log_c[idx]), 32'(c));
  endtask

  task automatic sb_drained(input string tag);
    chk({tag, "_m0_pending"}, 32'(q0.size()), 32'd0);
    chk({tag, "_m1_pending"}, 32'(q1.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wd[i] = '0; end
    ack_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_m.delete(); log_c.delete(); q0.delete(); q1.delete();
  endtask

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    vt[0] = '{0, 1'b1, 32'h010, 32'h1111_1111, GARB};
    vt[1] = '{1, 1'b1, 32'h014, 32'h2222_2222, GARB};
    vt[2] = '{1, 1'b0, 32'h010, 32'h0,         32'h1111_1111};
    vt[3] = '{0, 1'b0, 32'h014, 32'h0,         32'h2222_2222};
    vt[4] = '{1, 1'b0, 32'h100, 32'h0,         BEEF};
    vt[5] = '{0, 1'b1, 32'h3FC, 32'hFFFF_FFFF, GARB};
    vt[6] = '{1, 1'b0, 32'h3FC, 32'h0,         32'hFFFF_FFFF};
    vt[7] = '{0, 1'b0, 32'h020, 32'h0,         32'hC0DE_0008};

    // Tie after reset goes to m0; m1 follows after one IDLE cycle.
    do_reset();
    fork
      single(0, 1'b0, 32'h100, 32'h0, BEEF);
      single(1, 1'b0, 32'h104, 32'h0, 32'hC0DE_0041);
      begin
        @(negedge clk);
        chk("idle_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("idle_s_stb", 32'(s_stb_o), 32'd0);
        chk("idle_s_addr", s_addr_o, 32'd0);
        chk("idle_acks", 32'(ack), 32'd0);
        chk("idle_errs", 32'(err), 32'd0);
        chk("idle_m0_data", rdata[0], 32'd0);
        chk("idle_m1_data", rdata[1], 32'd0);
      end
    join
    expect_log("tie", 0, 0, 2);
    expect_log("tie", 1, 1, 5);
    sb_drained("tie");

    // Isolated transfers from the vector table.
    do_reset();
    for (int i = 0; i < 8; i++) single(vt[i].m, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);
    chk("table_ack_count", 32'(log_m.size()), 32'd8);
    sb_drained("table");

    // Strobe gap with cyc held keeps the grant while m1 waits.
    do_reset();
    fork
      begin
        q0.push_back(BEEF); q0.push_back(32'hC0DE_0041);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h100;
        wait_ack(0, ok_main);
        tick(); stb[0] = 1'b0;
        @(negedge clk);
        chk("gap_s_cyc", 32'(s_cyc_o), 32'd1);
        chk("gap_s_stb", 32'(s_stb_o), 32'd0);
        chk("gap_acks", 32'(ack), 32'd0);
        tick(); stb[0] = 1'b1; addr[0] = 32'h104;
        wait_ack(0, ok_main);
        tick(); cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
      end
      begin
        tick();
        single(1, 1'b0, 32'h108, 32'h0, 32'hC0DE_0042);
      end
    join
    expect_log("gap", 0, 0, 2);
    expect_log("gap", 1, 0, 4);
    expect_log("gap", 2, 1, 7);
    sb_drained("gap");

    // m1 three-beat write burst while m0 waits to read one of the words.
    do_reset();
    fork
      begin
        for (int b = 0; b < 3; b++) q1.push_back(GARB);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        for (int b = 0; b < 3; b++) begin
          addr[1] = 32'(b * 4);
          wd[1]   = 32'h1000_0000 + 32'(b);
          wait_ack(1, ok_main);
          tick();
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        tick();
      end
      begin
        tick();
        single(0, 1'b0, 32'h004, 32'h0, 32'h1000_0001);
      end
    join
    expect_log("burst", 0, 1, 2);
    expect_log("burst", 1, 1, 3);
    expect_log("burst", 2, 1, 4);
    expect_log("burst", 3, 0, 7);
    sb_drained("burst");

    // Continuous contention: strict alternation, 3 cycles per grant.
    do_reset();
    fork
      for (int k = 0; k < 4; k++) single(0, 1'b0, 32'h100, 32'h0, BEEF);
      for (int k = 0; k < 4; k++) single(1, 1'b1, 32'h200 + 32'(4 * k), 32'hBB00_0000 + 32'(k), GARB);
    join
    for (int i = 0; i < 8; i++) expect_log("rr", i, i % 2, 2 + 3 * i);
    sb_drained("rr");

    // Reset asserted during an m1 write.
    do_reset();
    q1.push_back(GARB);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10C; wd[1] = 32'h5555_AAAA;
    wait_ack(1, ok_main);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_s_we", 32'(s_we_o), 32'd0);
    chk("rst_s_addr", s_addr_o, 32'd0);
    chk("rst_s_data", s_data_o, 32'd0);
    chk("rst_acks", 32'(ack), 32'd0);
    chk("rst_m1_data", rdata[1], 32'd0);
    @(negedge clk);
    chk("rst_hold_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_hold_acks", 32'(ack), 32'd0);
    chk("rst_hold_errs", 32'(err), 32'd0);
    sb_drained("rst");
    do_reset();
    fork
      single(1, 1'b0, 32'h110, 32'h0, 32'hC0DE_0044);
      single(0, 1'b0, 32'h100, 32'h0, BEEF);
    join
    expect_log("rst_tie", 0, 0, 2);
    expect_log("rst_tie", 1, 1, 5);
    sb_drained("rst_tie");

    // Slave never acks.
    do_reset();
    ack_en = 1'b0;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
`ifdef BUS_ARB_TIMEOUT_EN
      chk($sformatf("stall_m0_err_c%0d", c), 32'(err[0]), 32'(c == 6));
      chk($sformatf("stall_s_cyc_c%0d", c), 32'(s_cyc_o), 32'(c >= 2 && c <= 5));
`else
      chk($sformatf("stall_m0_err_c%0d", c), 32'(err[0]), 32'd0);
      chk($sformatf("stall_s_cyc_c%0d", c), 32'(s_cyc_o), 32'(c >= 2));
`endif
      chk($sformatf("stall_acks_c%0d", c), 32'(ack), 32'd0);
      chk($sformatf("stall_m1_err_c%0d", c), 32'(err[1]), 32'd0);
      tick();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("stall_end_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("stall_end_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
